interrupt_controller: RTL and testbench

Collects external interrupt lines, prioritises them and sequences interrupt entry and exit for the processor core. It presents one request plus a 16-bit vector to the core and completes a request/acknowledge handshake during the core's COMMIT phase. It tracks in-service levels so that nested interrupts are allowed only at strictly higher priority. It sits between the board-level interrupt pins and the core's INT inputs and vector-fetch logic.

---
 rtl/interrupt_controller_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 35 +++
 rtl/interrupt_controller.sv | 138 +++++++++++++
 tb/tb_interrupt_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// the default vector-table placement.
package interrupt_controller_pkg;

    typedef enum logic {
        ICS_IDLE = 1'b0,
        ICS_REQ  = 1'b1
    } ics_state_t;

    localparam logic [15:0] DEF_VEC_BASE  = 16'h0010;
    localparam int          DEF_VEC_SHIFT = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// Single interrupt line: two-flop synchroniser followed by a delay flop so
// that a rising edge of the synchronised value can be detected.
module irq_sync_edge
    import interrupt_controller_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic IRQ,
    output logic SYNC,
    output logic RISE
);

    logic meta;
    logic stable;
    logic delayed;

    // Bring the asynchronous pin into the clock domain and keep one old copy.
    // NOTE: non-blocking assignments make each flop sample the pre-edge value
    // of the previous stage, which is what builds the pipeline.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta    <= 1'b0;
            stable  <= 1'b0;
            delayed <= 1'b0;
        end else begin
            meta    <= IRQ;
            stable  <= meta;
            delayed <= stable;
        end
    end

    assign SYNC = stable;
    assign RISE = stable & ~delayed;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises the pins, tracks pending and in-service
// levels, and runs the request/acknowledge handshake with the core.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int               N_IRQ     = 4,
    parameter logic [N_IRQ-1:0] EDGE_MASK = 4'b0011,
    parameter logic [15:0]      VEC_BASE  = DEF_VEC_BASE,
    parameter int               VEC_SHIFT = DEF_VEC_SHIFT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_IRQ-1:0] IRQ_IN,
    input  logic             COMMIT,
    input  logic             IE,
    input  logic             INT_ACK,
    input  logic             RETI,
    input  logic             EN_WR,
    input  logic [N_IRQ-1:0] EN_DIN,
    output logic             INT_REQ,
    output logic [15:0]      VECTOR,
    output logic [N_IRQ-1:0] EN,
    output logic [N_IRQ-1:0] PENDING,
    output logic [N_IRQ-1:0] IN_SERVICE
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    ics_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      vector_q;
    logic [N_IRQ-1:0] pending_q, in_service_q, en_q;

    logic [N_IRQ-1:0] sync, rise;
    logic [N_IRQ-1:0] lowest_is, below_is, eligible, ack_mask;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_valid;
    logic             latched_ok;
    logic             load_req;
    logic             ack_valid;

    genvar g;
    generate
        for (g = 0; g < N_IRQ; g++) begin : g_line
            irq_sync_edge u_sync (
                .CLK   (CLK),
                .RESET (RESET),
                .IRQ   (IRQ_IN[g]),
                .SYNC  (sync[g]),
                .RISE  (rise[g])
            );
        end
    endgenerate

    // Pick the highest-priority enabled pending line that can pre-empt the
    // innermost active handler.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lowest_is  = in_service_q & (~in_service_q + N_IRQ'(1));
        below_is   = (in_service_q == '0) ? '1 : lowest_is - N_IRQ'(1);
        eligible   = pending_q & en_q & below_is;
        cand_idx   = '0;
        cand_valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_idx   = IDX_W'(i);
                cand_valid = 1'b1;
            end
        end
        latched_ok = eligible[idx_q];
    end

    // Request/acknowledge sequencing; a valid acknowledge beats withdrawal.
    always_comb begin
        state_d   = state_q;
        load_req  = 1'b0;
        ack_valid = 1'b0;
        case (state_q)
            ICS_IDLE: begin
                if (IE && cand_valid) begin
                    state_d  = ICS_REQ;
                    load_req = 1'b1;
                end
            end
            ICS_REQ: begin
                if (INT_ACK && COMMIT) begin
                    ack_valid = 1'b1;
                    state_d   = ICS_IDLE;
                end else if (!IE || !latched_ok) begin
                    state_d = ICS_IDLE;
                end
            end
            default: state_d = ICS_IDLE;
        endcase
        ack_mask = ack_valid ? (N_IRQ'(1) << idx_q) : '0;
    end

    // State register plus the request target, frozen for the whole request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ICS_IDLE;
            idx_q    <= '0;
            vector_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_req) begin
                idx_q    <= cand_idx;
                vector_q <= VEC_BASE + (16'(cand_idx) << VEC_SHIFT);
            end
        end
    end

    // Status registers: RETI retires the innermost handler before the
    // acknowledged line is marked in service; a fresh edge wins over a clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q    <= '0;
            in_service_q <= '0;
            en_q         <= '0;
        end else begin
            pending_q    <= (EDGE_MASK & ((pending_q & ~ack_mask) | rise))
                          | (~EDGE_MASK & sync);
            in_service_q <= (RETI ? (in_service_q & ~lowest_is) : in_service_q)
                          | ack_mask;
            if (EN_WR) begin
                en_q <= EN_DIN;
            end
        end
    end

    assign INT_REQ    = (state_q == ICS_REQ);
    assign VECTOR     = vector_q;
    assign EN         = en_q;
    assign PENDING    = pending_q;
    assign IN_SERVICE = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed
// by random traffic, all compared against a behavioural model.
module tb_interrupt_controller;

    localparam logic [3:0]  EDGE_LINES = 4'b0011;
    localparam logic [15:0] BASE       = 16'h0010;
    localparam int          SPACING    = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  IRQ_IN = '0;
    logic        COMMIT = 1'b0;
    logic        IE = 1'b0;
    logic        INT_ACK = 1'b0;
    logic        RETI = 1'b0;
    logic        EN_WR = 1'b0;
    logic [3:0]  EN_DIN = '0;
    logic        INT_REQ;
    logic [15:0] VECTOR;
    logic [3:0]  EN;
    logic [3:0]  PENDING;
    logic [3:0]  IN_SERVICE;

    int n_checks = 0;
    int n_errors = 0;

    interrupt_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IRQ_IN     (IRQ_IN),
        .COMMIT     (COMMIT),
        .IE         (IE),
        .INT_ACK    (INT_ACK),
        .RETI       (RETI),
        .EN_WR      (EN_WR),
        .EN_DIN     (EN_DIN),
        .INT_REQ    (INT_REQ),
        .VECTOR     (VECTOR),
        .EN         (EN),
        .PENDING    (PENDING),
        .IN_SERVICE (IN_SERVICE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [3:0]  h0, h1, h2;   // pin samples taken 1, 2 and 3 edges ago
        logic [3:0]  pend, ins, en;
        logic        req;
        logic [1:0]  idx;
        logic [15:0] vec;
    } model_t;

    model_t      m = '0;
    logic [15:0] exp_q[$];

    function automatic model_t step(model_t c, logic [3:0] irq, logic ie, logic ack,
                                    logic commit, logic reti, logic en_wr, logic [3:0] en_din);
        model_t n = c;
        int  limit = 4;
        int  cand = -1;
        bit  ack_ok = 0;
        bit  qual;
        for (int i = 3; i >= 0; i--) if (c.ins[i]) limit = i;
        for (int i = 3; i >= 0; i--) if (i < limit && c.pend[i] && c.en[i]) cand = i;
        qual = (int'(c.idx) < limit) && c.pend[c.idx] && c.en[c.idx];
        if (!c.req) begin
            if (ie && cand >= 0) begin
                n.req = 1'b1;
                n.idx = 2'(cand);
                n.vec = BASE + 16'(cand * SPACING);
            end
        end else if (ack && commit) begin
            ack_ok = 1;
            n.req  = 1'b0;
        end else if (!ie || !qual) begin
            n.req = 1'b0;
        end
        if (reti && limit < 4) n.ins[limit] = 1'b0;
        if (ack_ok) n.ins[c.idx] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (EDGE_LINES[i])
                n.pend[i] = (c.pend[i] && !(ack_ok && int'(c.idx) == i)) || (c.h1[i] && !c.h2[i]);
            else
                n.pend[i] = c.h1[i];
        end
        if (en_wr) n.en = en_din;
        n.h0 = irq;
        n.h1 = c.h0;
        n.h2 = c.h1;
        return n;
    endfunction

    // Model advance; every new request predicted is queued for the monitor.
    initial forever begin
        model_t nxt;
        @(posedge CLK or posedge RESET);
        if (RESET) begin
            m = '0;
            exp_q.delete();
        end else begin
            nxt = step(m, IRQ_IN, IE, INT_ACK, COMMIT, RETI, EN_WR, EN_DIN);
            if (!m.req && nxt.req) exp_q.push_back(nxt.vec);
            m = nxt;
        end
    end

    // Monitor: compares status every cycle and the vector on each new request.
    initial begin
        logic prev_req = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_req = 1'b0;
            end else begin
                check("mon_int_req", 16'(INT_REQ), 16'(m.req));
                check("mon_pending", 16'(PENDING), 16'(m.pend));
                check("mon_in_service", 16'(IN_SERVICE), 16'(m.ins));
                check("mon_en", 16'(EN), 16'(m.en));
                if (INT_REQ && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL mon_vector: request with vector %h but none expected", VECTOR);
                    end else begin
                        check("mon_vector", VECTOR, exp_q.pop_front());
                    end
                end
                prev_req = INT_REQ;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_req(input string name, input logic [15:0] vec);
        for (int i = 0; i < 20 && !INT_REQ; i++) @(negedge CLK);
        check({name, "_req"}, 16'(INT_REQ), 16'd1);
        check({name, "_vec"}, VECTOR, vec);
    endtask

    task automatic wait_low(input string name);
        for (int i = 0; i < 20 && INT_REQ; i++) @(negedge CLK);
        check(name, 16'(INT_REQ), 16'd0);
    endtask

    task automatic ack_once();
        INT_ACK = 1'b1;
        COMMIT  = 1'b1;
        @(negedge CLK);
        INT_ACK = 1'b0;
        COMMIT  = 1'b0;
    endtask

    task automatic reti_once();
        RETI = 1'b1;
        @(negedge CLK);
        RETI = 1'b0;
    endtask

    task automatic pulse_pin(input int line);
        IRQ_IN[line] = 1'b1;
        cycles(3);
        IRQ_IN[line] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_int_req", 16'(INT_REQ), 16'd0);
        check("rst_vector", VECTOR, 16'h0000);
        check("rst_en", 16'(EN), 16'h0);
        check("rst_pending", 16'(PENDING), 16'h0);
        check("rst_in_service", 16'(IN_SERVICE), 16'h0);

        EN_WR = 1'b1; EN_DIN = 4'hF;
        @(negedge CLK);
        EN_WR = 1'b0;
        IE = 1'b1;

        // Line 1 edge: request exactly after the 4th edge.
        pulse_pin(1);
        @(negedge CLK);
        check("s1_req_edge4", 16'(INT_REQ), 16'd1);
        check("s1_vector", VECTOR, 16'h0014);
        ack_once();
        check("s1_in_service", 16'(IN_SERVICE), 16'h2);
        check("s1_pending1", 16'(PENDING[1]), 16'd0);
        check("s1_req_low", 16'(INT_REQ), 16'd0);

        // Nesting: line 3 blocked, line 0 pre-empts, then unwinds.
        IRQ_IN[3] = 1'b1;
        cycles(6);
        check("s2_blocked", 16'(INT_REQ), 16'd0);
        IRQ_IN[0] = 1'b1;
        wait_req("s2_line0", 16'h0010);
        IRQ_IN[0] = 1'b0;
        ack_once();
        check("s2_is_nested", 16'(IN_SERVICE), 16'h3);
        reti_once();
        check("s2_reti1", 16'(IN_SERVICE), 16'h2);
        reti_once();
        check("s2_reti2", 16'(IN_SERVICE), 16'h0);
        wait_req("s2_line3", 16'h001C);
        ack_once();
        IRQ_IN[3] = 1'b0;
        reti_once();
        cycles(4);

        // Level lines 2 and 3; releasing line 2 retargets to line 3.
        IRQ_IN[3:2] = 2'b11;
        wait_req("s3_line2", 16'h0018);
        IRQ_IN[2] = 1'b0;
        wait_low("s3_withdraw");
        wait_req("s3_line3", 16'h001C);

        // ACK without COMMIT ignored; IE drop withdraws and restores.
        INT_ACK = 1'b1;
        @(negedge CLK);
        INT_ACK = 1'b0;
        check("s4_ack_nocommit", 16'(INT_REQ), 16'd1);
        IE = 1'b0;
        @(negedge CLK);
        check("s4_ie_drop", 16'(INT_REQ), 16'd0);
        check("s4_pending_kept", 16'(PENDING), 16'h8);
        IE = 1'b1;
        wait_req("s4_restore", 16'h001C);
        ack_once();
        IRQ_IN[3] = 1'b0;
        reti_once();
        cycles(4);

        // New edge on line 0 in the very cycle its acknowledge lands.
        pulse_pin(0);
        wait_req("s5_line0", 16'h0010);
        cycles(3);
        IRQ_IN[0] = 1'b1;
        cycles(2);
        ack_once();
        check("s5_pending_kept", 16'(PENDING[0]), 16'd1);
        check("s5_in_service", 16'(IN_SERVICE), 16'h1);
        IRQ_IN[0] = 1'b0;
        reti_once();
        wait_req("s5_rerequest", 16'h0010);
        ack_once();
        reti_once();
        cycles(4);

        // Asynchronous reset in the middle of a nested request.
        pulse_pin(1);
        wait_req("s6_line1", 16'h0014);
        ack_once();
        pulse_pin(0);
        wait_req("s6_line0", 16'h0010);
        #2 RESET = 1'b1;
        #1;
        check("s6_int_req", 16'(INT_REQ), 16'd0);
        check("s6_vector", VECTOR, 16'h0000);
        check("s6_in_service", 16'(IN_SERVICE), 16'h0);
        check("s6_pending", 16'(PENDING), 16'h0);
        check("s6_en", 16'(EN), 16'h0);
        @(negedge CLK);
        RESET = 1'b0;
        EN_WR = 1'b1; EN_DIN = 4'hF;
        @(negedge CLK);
        EN_WR = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] flip = '0;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(7) == 0);
            IRQ_IN  = IRQ_IN ^ flip;
            IE      = ($urandom_range(15) != 0);
            INT_ACK = ($urandom_range(3) == 0);
            COMMIT  = $urandom_range(1) == 1;
            RETI    = ($urandom_range(7) == 0);
            EN_WR   = ($urandom_range(31) == 0);
            EN_DIN  = 4'($urandom_range(15));
            @(negedge CLK);
        end
        INT_ACK = 1'b0; RETI = 1'b0; EN_WR = 1'b0;
        @(negedge CLK);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
